// File: rtl/baud_pkg.sv
// Shared constants for the UART baud tick generator.
// Divisor presets assume a 100 MHz clock and 16x oversampling.
package baud_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DIV_MIN     = 2;
    localparam int unsigned OS_DEFAULT  = 16;

    // 100e6 / (16 * baud) split into integer and 1/16ths
    localparam int unsigned DIV_9600    = 651;
    localparam int unsigned FRAC_9600   = 1;
    localparam int unsigned DIV_115200  = 54;
    localparam int unsigned FRAC_115200 = 4;

endpackage

// File: rtl/baud_frac_counter.sv
// Fractional-N period counter: shadow divisor, carry accumulator,
// and the cycle counter that flags the last cycle of each period.
module baud_frac_counter
    import baud_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              wrap
);

    localparam int CW = DIV_W + 1;

    logic [DIV_W-1:0]  sh_int;
    logic [DIV_W-1:0]  in_int;
    logic [DIV_W-1:0]  eff_int;
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W-1:0] eff_frac;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     plen;
    logic              start;

    always_comb begin
        in_int   = (div_int < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_int;
        eff_int  = load ? in_int : sh_int;
        eff_frac = load ? div_frac : sh_frac;
        sum      = {1'b0, acc} + {1'b0, eff_frac};
        start    = en && (cnt == '0);
        wrap     = en && !sync_clr && !start
                   && (cnt == plen - CW'(1));
    end

    // plen is the active divisor: latched once per period at its first cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_int  <= DIV_W'(DIV_MIN);
            sh_frac <= '0;
            acc     <= '0;
            cnt     <= '0;
            plen    <= CW'(DIV_MIN);
        end else begin
            if (load) begin
                sh_int  <= in_int;
                sh_frac <= div_frac;
            end
            if (sync_clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (en) begin
                if (start) begin
                    acc  <= sum[FRAC_W-1:0];
                    plen <= {1'b0, eff_int} + CW'(sum[FRAC_W]);
                    cnt  <= CW'(1);
                end else if (wrap) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: oversample and bit-rate strobes for the UART
// RX/TX FSMs, with runtime integer+fractional divisor.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = OS_DEFAULT,
    parameter int PH_W       = $clog2(OVERSAMPLE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick_os,
    output logic              tick_baud,
    output logic [PH_W-1:0]   phase
);

    logic wrap;

    baud_frac_counter #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .load     (load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .wrap     (wrap)
    );

    // OVERSAMPLE is a power of two, so phase wraps by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_os   <= 1'b0;
            tick_baud <= 1'b0;
            phase     <= '0;
        end else begin
            tick_os   <= wrap;
            tick_baud <= wrap && (phase == PH_W'(OVERSAMPLE - 1));
            if (sync_clr) begin
                phase <= '0;
            end else if (wrap) begin
                phase <= phase + PH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: period-level reference model
// predicts each tick; a monitor pops and compares on every tick_os.
module tb_baud_tick_gen;
    import baud_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sync_clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        tick_os;
    logic        tick_baud;
    logic [3:0]  phase;

    baud_tick_gen #(
        .DIV_W      (16),
        .FRAC_W     (4),
        .OVERSAMPLE (16),
        .PH_W       (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_clr  (sync_clr),
        .load      (load),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .tick_os   (tick_os),
        .tick_baud (tick_baud),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ph;
        int baud;
    } ev_t;

    ev_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int os_cnt = 0;
    int baud_cnt = 0;

    // reference model: divisor in force, progress through current period
    int m_d = 2;
    int m_f = 0;
    int m_prog = 0;
    int m_len = 0;
    int m_acc = 0;
    int m_ticks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic void model_rst();
        m_d = 2; m_f = 0; m_prog = 0;
        m_len = 0; m_acc = 0; m_ticks = 0;
    endfunction

    task automatic model_step();
        ev_t e;
        int s;
        if (load) begin
            m_d = (div_int < 2) ? 2 : int'(div_int);
            m_f = int'(div_frac);
        end
        if (sync_clr) begin
            m_prog = 0; m_acc = 0; m_ticks = 0;
            return;
        end
        if (!en) return;
        if (m_prog == 0) begin
            s = m_acc + m_f;
            m_len = m_d + ((s >= 16) ? 1 : 0);
            m_acc = s % 16;
        end
        m_prog++;
        if (m_prog == m_len) begin
            m_prog = 0;
            m_ticks = (m_ticks + 1) % 16;
            e.cyc = cyc + 1;
            e.ph = m_ticks;
            e.baud = (m_ticks == 0) ? 1 : 0;
            q.push_back(e);
        end
    endtask

    task automatic drive(input bit e, input bit c, input bit l,
                         input int di, input int df);
        @(negedge clk);
        en = e; sync_clr = c; load = l;
        div_int = 16'(di); div_frac = 4'(df);
        if (rst_n) model_step();
    endtask

    task automatic run1(input bit e, input bit c, input bit l,
                        input int di, input int df);
        drive(e, c, l, di, df);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++)
            drive(e, 0, 0, int'(div_int), int'(div_frac));
    endtask

    always @(posedge clk) begin
        ev_t e;
        #1;
        cyc++;
        if (rst_n) begin
            if (tick_os) os_cnt++;
            if (tick_baud) baud_cnt++;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                total++; bad++;
                $display("FAIL missed_tick: got no tick_os, expected at cycle %0d", e.cyc);
            end
            if (tick_os) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_tick: got tick at cycle %0d, expected none", cyc);
                end else begin
                    e = q.pop_front();
                    chk("tick_cycle", cyc, e.cyc);
                    chk("tick_phase", int'(phase), e.ph);
                    chk("tick_baud", int'(tick_baud), e.baud);
                end
            end else if (tick_baud) begin
                total++; bad++;
                $display("FAIL stray_baud: got tick_baud=1 expected 0 at cycle %0d", cyc);
            end
        end
    end

    initial begin
        int b0;
        int o0;
        int p0;
        int g;

        repeat (3) @(negedge clk);
        chk("rst_tick_os", int'(tick_os), 0);
        chk("rst_tick_baud", int'(tick_baud), 0);
        chk("rst_phase", int'(phase), 0);
        rst_n = 1'b1;
        model_rst();

        // default divisor 2 runs before any load
        idle(20, 1);

        // D=4, F=0
        run1(1, 1, 1, 4, 0);
        idle(200, 1);
        b0 = baud_cnt;
        idle(128, 1);
        @(posedge clk); #2;
        chk("t1_baud_per_128", baud_cnt - b0, 2);

        // D=4, F=8: 16 ticks in 72 cycles
        run1(1, 1, 1, 4, 8);
        o0 = os_cnt;
        for (int i = 0; i < 72; i++) run1(1, 0, 0, 4, 8);
        chk("t2_os_in_72", os_cnt - o0, 16);
        chk("t2_tick_at_72", int'(tick_os), 1);
        chk("t2_baud_at_72", int'(tick_baud), 1);

        // pause mid-period at cnt=2
        run1(1, 1, 1, 4, 0);
        run1(1, 0, 0, 4, 0);
        run1(1, 0, 0, 4, 0);
        p0 = int'(phase);
        for (int i = 0; i < 7; i++) run1(0, 0, 0, 4, 0);
        chk("t4_phase_hold", int'(phase), p0);
        run1(1, 0, 0, 4, 0);
        chk("t4_no_tick_1", int'(tick_os), 0);
        run1(1, 0, 0, 4, 0);
        chk("t4_resume_tick", int'(tick_os), 1);
        chk("t4_phase_step", int'(phase), (p0 + 1) % 16);

        // load D=8 mid-period
        run1(1, 1, 1, 4, 0);
        run1(1, 0, 0, 4, 0);
        run1(1, 0, 1, 8, 0);
        run1(1, 0, 0, 8, 0);
        run1(1, 0, 0, 8, 0);
        chk("t5_old_period", int'(tick_os), 1);
        for (int i = 0; i < 7; i++) run1(1, 0, 0, 8, 0);
        chk("t5_not_yet", int'(tick_os), 0);
        run1(1, 0, 0, 8, 0);
        chk("t5_new_period", int'(tick_os), 1);

        // load while paused takes effect on first period
        run1(0, 1, 1, 4, 0);
        run1(0, 0, 1, 8, 0);
        for (int i = 0; i < 7; i++) run1(1, 0, 0, 8, 0);
        run1(1, 0, 0, 8, 0);
        chk("t5_paused_load", int'(tick_os), 1);

        // realign at phase 9
        run1(1, 1, 1, 4, 0);
        g = 0;
        while (phase != 4'd9 && g < 200) begin
            run1(1, 0, 0, 4, 0);
            g++;
        end
        chk("t6_reach_ph9", int'(phase), 9);
        run1(1, 1, 0, 4, 0);
        chk("t6_clr_phase", int'(phase), 0);
        chk("t6_clr_no_tick", int'(tick_os), 0);
        idle(40, 1);

        // clamp of small divisors
        run1(1, 1, 1, 0, 0);
        idle(40, 1);
        run1(1, 1, 1, 1, 3);
        idle(60, 1);

        // 9600 baud over four bit times
        run1(1, 1, 1, DIV_9600, FRAC_9600);
        b0 = baud_cnt;
        idle(41668, 1);
        @(posedge clk); #2;
        chk("t3_9600_rate", ((baud_cnt - b0) >= 3 && (baud_cnt - b0) <= 5) ? 1 : 0, 1);

        // random control traffic
        run1(1, 1, 1, 3, 5);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 8) != 0, ($urandom % 64) == 0,
                  ($urandom % 40) == 0, $urandom_range(0, 12),
                  $urandom % 16);
        end

        // async reset while a tick is high
        run1(1, 1, 1, 4, 0);
        g = 0;
        while (!(tick_os && phase != 0) && g < 200) begin
            run1(1, 0, 0, 4, 0);
            g++;
        end
        chk("t6_pre_rst_tick", int'(tick_os), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tick_os", int'(tick_os), 0);
        chk("t6_rst_tick_baud", int'(tick_baud), 0);
        chk("t6_rst_phase", int'(phase), 0);
        q.delete();
        model_rst();
        @(negedge clk);
        en = 1'b0; sync_clr = 1'b0; load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(30, 1);
        idle(3, 0);
        @(posedge clk); #2;
        chk("drain_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
